// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: routes CPU memory requests either to external word memory
// (req/ack handshake with timeout) or to the on-chip IO register block.
module mem_bus_ctrl #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned LED_W   = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [31:0]      iCpuAddr,
  input  logic [31:0]      iCpuWData,
  input  logic             iCpuRead,
  input  logic             iCpuWrite,
  output logic [31:0]      oCpuRData,
  output logic             oCpuStall,
  output logic [31:0]      oExtAddr,
  output logic [31:0]      oExtWData,
  output logic             oExtWe,
  output logic             oExtReq,
  input  logic             iExtAck,
  input  logic [31:0]      iExtRData,
  output logic [LED_W-1:0] oLed
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned   WAIT_W       = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [31:0]   TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam logic [31:0]   OFF_LED      = 32'd0;
  localparam logic [31:0]   OFF_CYCLE    = 32'd4;
  localparam logic [31:0]   OFF_ERR      = 32'd8;

  logic [1:0]        state_q, state_d;
  logic              ext_req_q, ext_req_d;
  logic              ext_we_q, ext_we_d;
  logic [31:0]       ext_addr_q, ext_addr_d;
  logic [31:0]       ext_wdata_q, ext_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [1:0]        err_q, err_d;

  logic        cpu_acc, misal, is_io, io_wr, io_rd, ext_start;
  logic [31:0] io_off, io_rdata_c, rdata_c;
  logic        stall_c;

  // Request decode; only meaningful while idle, the other states own the bus.
  always_comb begin
    cpu_acc   = iCpuRead | iCpuWrite;
    misal     = cpu_acc & (iCpuAddr[1:0] != 2'b00);
    is_io     = iCpuAddr >= IO_BASE;
    io_off    = iCpuAddr - IO_BASE;
    io_wr     = (state_q == S_IDLE) & cpu_acc & ~misal & is_io & iCpuWrite;
    io_rd     = (state_q == S_IDLE) & cpu_acc & ~misal & is_io & iCpuRead & ~iCpuWrite;
    ext_start = (state_q == S_IDLE) & cpu_acc & ~misal & ~is_io;
  end

  // IO register read mux.
  always_comb begin
    io_rdata_c = 32'h0;
    if (io_off == OFF_LED) begin
      io_rdata_c = 32'(led_q);
    end else if (io_off == OFF_CYCLE) begin
      io_rdata_c = cycle_q;
    end else if (io_off == OFF_ERR) begin
      io_rdata_c = {30'h0, err_q};
    end
  end

  // Next-state, register updates and combinational CPU-side outputs.
  always_comb begin
    state_d     = state_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    rdata_d     = rdata_q;
    wait_d      = wait_q;
    led_d       = led_q;
    cycle_d     = cycle_q + 32'd1;
    err_d       = err_q;
    stall_c     = 1'b0;
    rdata_c     = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (io_wr && io_off == OFF_LED) begin
          led_d = iCpuWData[LED_W-1:0];
        end
        if (io_wr && io_off == OFF_CYCLE) begin
          cycle_d = iCpuWData;
        end
        if (io_wr && io_off == OFF_ERR) begin
          err_d = err_q & ~iCpuWData[1:0];
        end
        if (misal) begin
          err_d[1] = 1'b1;
        end
        if (io_rd) begin
          rdata_c = io_rdata_c;
        end
        if (ext_start) begin
          stall_c     = 1'b1;
          ext_req_d   = 1'b1;
          ext_we_d    = iCpuWrite;
          ext_addr_d  = iCpuAddr;
          ext_wdata_d = iCpuWData;
          wait_d      = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        wait_d  = wait_q + WAIT_W'(1);
        if (iExtAck) begin
          rdata_d   = ext_we_q ? 32'h0 : iExtRData;
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          state_d   = S_DONE;
        end else if (wait_q == WAIT_LAST) begin
          rdata_d   = ext_we_q ? 32'h0 : TIMEOUT_DATA;
          err_d[0]  = 1'b1;
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        rdata_c = rdata_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and register bank; reset aborts any outstanding external access.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= 32'h0;
      ext_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      wait_q      <= '0;
      led_q       <= '0;
      cycle_q     <= 32'h0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      rdata_q     <= rdata_d;
      wait_q      <= wait_d;
      led_q       <= led_d;
      cycle_q     <= cycle_d;
      err_q       <= err_d;
    end
  end

  assign oCpuStall = stall_c & ~iRst;
  assign oCpuRData = rdata_c;
  assign oExtReq   = ext_req_q;
  assign oExtWe    = ext_we_q;
  assign oExtAddr  = ext_addr_q;
  assign oExtWData = ext_wdata_q;
  assign oLed      = led_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed table, hand sequences and random traffic against a
// transaction-level model of the bus controller.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
  localparam int          TIMEOUT = 16;
  localparam int          LED_W   = 8;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [31:0] iCpuAddr, iCpuWData, iExtRData;
  logic        iCpuRead, iCpuWrite, iExtAck;
  logic [31:0] oCpuRData, oExtAddr, oExtWData;
  logic        oCpuStall, oExtWe, oExtReq;
  logic [7:0]  oLed;

  mem_bus_ctrl #(.IO_BASE(IO_BASE), .TIMEOUT(TIMEOUT), .LED_W(LED_W)) dut (
    .iClk(iClk), .iRst(iRst),
    .iCpuAddr(iCpuAddr), .iCpuWData(iCpuWData),
    .iCpuRead(iCpuRead), .iCpuWrite(iCpuWrite),
    .oCpuRData(oCpuRData), .oCpuStall(oCpuStall),
    .oExtAddr(oExtAddr), .oExtWData(oExtWData),
    .oExtWe(oExtWe), .oExtReq(oExtReq),
    .iExtAck(iExtAck), .iExtRData(iExtRData),
    .oLed(oLed)
  );

  always #5 iClk = ~iClk;

  // Clock edges since reset release; the CYCLE register is modelled from this.
  int tick;
  always @(posedge iClk or posedge iRst) begin
    if (iRst) tick <= 0;
    else      tick <= tick + 1;
  end

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state.
  logic [7:0]  m_led;
  logic [1:0]  m_err;
  logic [31:0] m_cbase;
  int          m_ctick;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_led;
  } vec_t;
  vec_t vecs [16];

  logic [31:0] offs [8] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd1, 32'd2, 32'd6, 32'd8};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] cyc_at(input int t);
    return m_cbase + 32'(t - m_ctick);
  endfunction

  task automatic model_reset();
    m_led = 8'h0; m_err = 2'b00; m_cbase = 32'h0; m_ctick = 0;
  endtask

  task automatic idle(input int n);
    iCpuRead = 1'b0; iCpuWrite = 1'b0;
    repeat (n) begin @(posedge iClk); #1; end
  endtask

  // Zero-wait access (IO region or misaligned anywhere).
  task automatic do_io(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] got);
    logic        mis;
    logic [31:0] off, exp_v;
    int          t;
    iCpuRead = rd; iCpuWrite = wr; iCpuAddr = addr; iCpuWData = wdata;
    @(negedge iClk);
    t     = tick;
    mis   = (addr[1:0] != 2'b00);
    off   = addr - IO_BASE;
    exp_v = 32'h0;
    if (!mis && !wr) begin
      if (off == 32'd0)      exp_v = {24'h0, m_led};
      else if (off == 32'd4) exp_v = cyc_at(t);
      else if (off == 32'd8) exp_v = {30'h0, m_err};
    end
    got = oCpuRData;
    chk("io_rdata", got, exp_v);
    chk("io_stall", 32'(oCpuStall), 32'h0);
    chk("io_extreq", 32'(oExtReq), 32'h0);
    chk("io_led", 32'(oLed), 32'(m_led));
    @(posedge iClk); #1;
    if (mis) m_err[1] = 1'b1;
    else if (wr) begin
      if (off == 32'd0) m_led = wdata[7:0];
      else if (off == 32'd4) begin m_cbase = wdata; m_ctick = t + 1; end
      else if (off == 32'd8) m_err = m_err & ~wdata[1:0];
    end
    iCpuRead = 1'b0; iCpuWrite = 1'b0;
  endtask

  // External access; ack_at = REQ cycle carrying the ack (0 = never).
  task automatic do_ext(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_at,
                        input logic [31:0] ack_data, output logic [31:0] got,
                        output int reqs);
    int          stalls, we_hi, exp_reqs;
    logic        done, acked;
    logic [31:0] exp_v;
    acked    = (ack_at >= 1 && ack_at <= TIMEOUT);
    exp_reqs = acked ? ack_at : TIMEOUT;
    exp_v    = wr ? 32'h0 : (acked ? ack_data : 32'hDEAD_BEEF);
    stalls = 0; reqs = 0; we_hi = 0; done = 1'b0; got = 32'h0;
    iCpuRead = rd; iCpuWrite = wr; iCpuAddr = addr; iCpuWData = wdata;
    for (int c = 0; c < TIMEOUT + 8 && !done; c++) begin
      @(negedge iClk);
      if (oExtReq) begin
        reqs++;
        if (oExtWe) we_hi++;
        if (reqs == 1) begin
          chk("ext_addr", oExtAddr, addr);
          if (wr) chk("ext_wdata", oExtWData, wdata);
        end
        iExtAck   = (reqs == ack_at);
        iExtRData = ack_data;
      end
      if (oCpuStall) stalls++;
      else begin
        done = 1'b1;
        got  = oCpuRData;
        chk("done_we", 32'(oExtWe), 32'h0);
        iExtAck = (ack_at > TIMEOUT);
      end
      @(posedge iClk); #1;
      iExtAck = 1'b0; iExtRData = $urandom;
    end
    iCpuRead = 1'b0; iCpuWrite = 1'b0;
    if (!done) chk("ext_done_bound", 32'h0, 32'h1);
    chk("ext_stalls", 32'(stalls), 32'(1 + exp_reqs));
    chk("ext_reqs", 32'(reqs), 32'(exp_reqs));
    chk("ext_we_cycles", 32'(we_hi), wr ? 32'(exp_reqs) : 32'h0);
    chk("ext_rdata", got, exp_v);
    if (!acked) m_err[0] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, addr, wd;
    logic [1:0]  rw;
    int          reqs, kind, ack_at;

    iRst = 1'b1; iCpuAddr = 32'h0; iCpuWData = 32'h0; iCpuRead = 1'b0;
    iCpuWrite = 1'b0; iExtAck = 1'b0; iExtRData = 32'h0;
    model_reset();

    vecs[0]  = '{1'b0, 1'b1, IO_BASE,          32'h0000_00A5, 32'h0, 8'hA5};
    vecs[1]  = '{1'b1, 1'b0, IO_BASE,          32'h0,         32'h0000_00A5, 8'hA5};
    vecs[2]  = '{1'b0, 1'b1, IO_BASE,          32'h0000_01FF, 32'h0, 8'hFF};
    vecs[3]  = '{1'b1, 1'b0, IO_BASE,          32'h0,         32'h0000_00FF, 8'hFF};
    vecs[4]  = '{1'b1, 1'b0, IO_BASE + 32'hC,  32'h0,         32'h0, 8'hFF};
    vecs[5]  = '{1'b0, 1'b1, IO_BASE + 32'hC,  32'h55,        32'h0, 8'hFF};
    vecs[6]  = '{1'b1, 1'b0, IO_BASE + 32'h8,  32'h0,         32'h0, 8'hFF};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0102,    32'hDEAD_CAFE, 32'h0, 8'hFF};
    vecs[8]  = '{1'b1, 1'b0, IO_BASE + 32'h8,  32'h0,         32'h2, 8'hFF};
    vecs[9]  = '{1'b1, 1'b1, IO_BASE + 32'h8,  32'h2,         32'h0, 8'hFF};
    vecs[10] = '{1'b1, 1'b0, IO_BASE + 32'h8,  32'h0,         32'h0, 8'hFF};
    vecs[11] = '{1'b1, 1'b0, IO_BASE + 32'h1,  32'h0,         32'h0, 8'hFF};
    vecs[12] = '{1'b1, 1'b0, IO_BASE + 32'h8,  32'h0,         32'h2, 8'hFF};
    vecs[13] = '{1'b0, 1'b1, IO_BASE + 32'h8,  32'h3,         32'h0, 8'hFF};
    vecs[14] = '{1'b1, 1'b0, IO_BASE + 32'h8,  32'h0,         32'h0, 8'hFF};
    vecs[15] = '{1'b1, 1'b1, IO_BASE,          32'h0000_003C, 32'h0, 8'h3C};

    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;

    // Reset state
    @(negedge iClk);
    chk("rst_stall", 32'(oCpuStall), 32'h0);
    chk("rst_req", 32'(oExtReq), 32'h0);
    chk("rst_we", 32'(oExtWe), 32'h0);
    chk("rst_addr", oExtAddr, 32'h0);
    chk("rst_wdata", oExtWData, 32'h0);
    chk("rst_led", 32'(oLed), 32'h0);
    chk("rst_rdata", oCpuRData, 32'h0);
    @(posedge iClk); #1;

    // Minimum-latency read, delayed write, timeout read
    do_ext(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h1234_5678, got, reqs);
    chk("rd100_data", got, 32'h1234_5678);
    chk("rd100_reqs", 32'(reqs), 32'd1);
    do_ext(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 5, 32'h0BAD_0BAD, got, reqs);
    chk("wr40_reqs", 32'(reqs), 32'd5);
    chk("wr40_data", got, 32'h0);
    do_ext(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h0, got, reqs);
    chk("to_data", got, 32'hDEAD_BEEF);
    chk("to_reqs", 32'(reqs), 32'd16);
    do_io(1'b1, 1'b0, IO_BASE + 32'h8, 32'h0, got);
    chk("to_err", got, 32'h1);
    do_io(1'b0, 1'b1, IO_BASE + 32'h8, 32'h1, got);
    do_io(1'b1, 1'b0, IO_BASE + 32'h8, 32'h0, got);
    chk("to_err_clr", got, 32'h0);

    // Directed IO / misaligned table
    for (int i = 0; i < 16; i++) begin
      do_io(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, got);
      chk($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_led", i), 32'(oLed), 32'(vecs[i].exp_led));
    end

    // CYCLE wrap
    do_io(1'b0, 1'b1, IO_BASE + 32'h4, 32'hFFFF_FFFE, got);
    idle(3);
    do_io(1'b1, 1'b0, IO_BASE + 32'h4, 32'h0, got);
    chk("cycle_wrap", got, 32'h0000_0001);

    // Back-to-back external accesses, late ack after timeout
    do_ext(1'b1, 1'b0, 32'h500, 32'h0, 2, 32'h0A0B_0C0D, got, reqs);
    do_ext(1'b1, 1'b0, 32'h504, 32'h0, TIMEOUT, 32'h1111_2222, got, reqs);
    do_ext(1'b0, 1'b1, 32'h508, 32'h7777_8888, TIMEOUT + 2, 32'h0, got, reqs);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      wd   = $urandom;
      rw   = 2'($urandom_range(1, 3));
      if (kind < 4) begin
        addr = IO_BASE + offs[$urandom_range(0, 7)];
        do_io(rw[0], rw[1], addr, wd, got);
      end else if (kind < 5) begin
        addr = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(1, 3));
        do_io(rw[0], rw[1], addr, wd, got);
      end else begin
        addr   = $urandom & 32'h7FFF_FFFC;
        ack_at = $urandom_range(0, TIMEOUT + 2);
        do_ext(rw[0], rw[1], addr, wd, ack_at, $urandom, got, reqs);
      end
    end

    // Reset asserted mid-access
    iCpuRead = 1'b1; iCpuWrite = 1'b0; iCpuAddr = 32'h300;
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    @(negedge iClk);
    chk("mid_req_before", 32'(oExtReq), 32'h1);
    iRst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(oExtReq), 32'h0);
    chk("mid_rst_stall", 32'(oCpuStall), 32'h0);
    @(posedge iClk); #1;
    iCpuRead = 1'b0; iExtAck = 1'b1; iExtRData = 32'h5A5A_5A5A;
    iRst = 1'b0;
    model_reset();
    @(negedge iClk);
    chk("post_rst_req", 32'(oExtReq), 32'h0);
    chk("post_rst_stall", 32'(oCpuStall), 32'h0);
    chk("post_rst_led", 32'(oLed), 32'h0);
    @(posedge iClk); #1;
    iExtAck = 1'b0;
    @(negedge iClk);
    chk("late_ack_req", 32'(oExtReq), 32'h0);
    chk("late_ack_rdata", oCpuRData, 32'h0);
    @(posedge iClk); #1;
    do_io(1'b1, 1'b0, IO_BASE + 32'h8, 32'h0, got);
    chk("post_rst_err", got, 32'h0);
    do_ext(1'b1, 1'b0, 32'h600, 32'h0, 3, 32'hFEED_FACE, got, reqs);
    chk("post_rst_ext", got, 32'hFEED_FACE);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
